// File: rtl/vga_card_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_card_renderer_if
//  Description : Memory-side bus bundle for the card renderer.
//                Card-memory fetch handshake: cardReq / RAMaddr (to memory),
//                cardAck / cardIndex (from memory).
//                Sprite ROM port: spriteAddr (to ROM), spriteColor (from ROM,
//                valid ROM_LAT cycles after the address).
//                master = renderer side, slave = memory / ROM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_card_renderer_if #(
    parameter int ADDR_W = 17
) ();
    logic              cardReq;
    logic [31:0]       RAMaddr;
    logic              cardAck;
    logic [31:0]       cardIndex;
    logic [ADDR_W-1:0] spriteAddr;
    logic [11:0]       spriteColor;

    modport master (
        output cardReq,
        output RAMaddr,
        output spriteAddr,
        input  cardAck,
        input  cardIndex,
        input  spriteColor
    );

    modport slave (
        input  cardReq,
        input  RAMaddr,
        input  spriteAddr,
        output cardAck,
        output cardIndex,
        output spriteColor
    );
endinterface
`default_nettype wire

// File: rtl/vga_card_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_card_renderer
//  Description : Draws a row of NUM_SLOTS card sprites. Once per frame a fetch
//                FSM reads the sprite index of every slot from card memory into
//                a shadow table; the shadow table is copied to the display
//                table only at a frame boundary, so drawing never tears.
//                The pixel path maps (x,y) to a sprite ROM address, waits
//                ROM_LAT cycles for the colour and registers the VGA outputs.
//  Ports       : clk, reset            - pixel clock, sync active-high reset
//                x, y, active          - pixel position / visible-area flag
//                hSyncIn, vSyncIn      - raw syncs from the timing generator
//                screenEnd             - one-cycle end-of-frame pulse
//                bus (master)          - card fetch handshake + sprite ROM port
//                hSync, vSync          - syncs aligned with the colour
//                VGA_R, VGA_G, VGA_B   - 4-bit colour channels
//                fetchErr              - sticky card-fetch timeout flag
//                Latency x/y/active/syncs -> outputs: ROM_LAT+2 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_card_renderer #(
    parameter int NUM_SLOTS    = 6,
    parameter int SLOT_PITCH   = 95,
    parameter int X_OFF        = 10,
    parameter int ROW_Y        = 20,
    parameter int CARD_W       = 85,
    parameter int CARD_H       = 105,
    parameter int SPRITE_COUNT = 13,
    parameter int ROM_LAT      = 2,
    parameter int ADDR_W       = 17,
    parameter int CARD_BASE    = 16,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic        active,
    input  logic        hSyncIn,
    input  logic        vSyncIn,
    input  logic        screenEnd,
    vga_card_renderer_if.master bus,
    output logic        hSync,
    output logic        vSync,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        fetchErr
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int AW     = ADDR_W + 1;

    localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [TO_W-1:0]   c_to_last   = TO_W'(TIMEOUT - 1);
    localparam logic [31:0]       c_card_base = 32'(CARD_BASE);

    localparam logic [9:0] c_x_off    = 10'(X_OFF);
    localparam logic [9:0] c_pitch    = 10'(SLOT_PITCH);
    localparam logic [9:0] c_nslot    = 10'(NUM_SLOTS);
    localparam logic [9:0] c_card_w   = 10'(CARD_W);
    localparam logic [8:0] c_row_y    = 9'(ROW_Y);
    localparam logic [8:0] c_card_h   = 9'(CARD_H);
    localparam logic [31:0] c_sprites = 32'(SPRITE_COUNT);
    localparam logic [AW-1:0] c_spr_size = AW'(CARD_W * CARD_H);
    localparam logic [AW-1:0] c_row_len  = AW'(CARD_W);

    // ------------------------------------------------------------------------
    // Card fetch FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t            r_state;
    logic [SLOT_W-1:0] r_slot;
    logic [TO_W-1:0]   r_wait_cnt;
    logic              r_card_req;
    logic [31:0]       r_ram_addr;
    logic              r_fetch_err;
    logic [31:0]       r_shadow  [NUM_SLOTS];
    logic [31:0]       r_display [NUM_SLOTS];

    logic w_timeout;
    assign w_timeout = (r_wait_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_slot      <= '0;
            r_wait_cnt  <= '0;
            r_card_req  <= 1'b0;
            r_ram_addr  <= c_card_base;
            r_fetch_err <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_shadow[i]  <= '0;
                r_display[i] <= '0;
            end
        end else begin
            // Request is a one-cycle strobe; RAMaddr holds between requests.
            r_card_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (screenEnd) begin
                        r_state    <= ST_REQ;
                        r_slot     <= '0;
                        r_card_req <= 1'b1;
                        r_ram_addr <= c_card_base;
                    end
                end
                ST_REQ: begin
                    r_state    <= ST_WAIT;
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (bus.cardAck || w_timeout) begin
                        if (bus.cardAck) begin
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                if (r_slot == SLOT_W'(i)) begin
                                    r_shadow[i] <= bus.cardIndex;
                                end
                            end
                        end else begin
                            r_fetch_err <= 1'b1;
                        end
                        if (r_slot == c_last_slot) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_slot     <= r_slot + SLOT_W'(1);
                            r_state    <= ST_REQ;
                            r_card_req <= 1'b1;
                            r_ram_addr <= c_card_base + 32'(r_slot) + 32'd1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Frame boundary: publish the completed fetch, start the next.
                    if (screenEnd) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            r_display[i] <= r_shadow[i];
                        end
                        r_state    <= ST_REQ;
                        r_slot     <= '0;
                        r_card_req <= 1'b1;
                        r_ram_addr <= c_card_base;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cardReq = r_card_req;
    assign bus.RAMaddr = r_ram_addr;
    assign fetchErr    = r_fetch_err;

    // ------------------------------------------------------------------------
    // Pixel stage 1: slot decode and sprite address
    // ------------------------------------------------------------------------
    logic          w_x_ok;
    logic [9:0]    w_dx;
    logic [9:0]    w_s;
    logic [9:0]    w_xo;
    logic [8:0]    w_yo;
    logic          w_in_card;
    logic [31:0]   w_idx;
    logic          w_idx_ok;
    logic          w_draw;
    logic [AW-1:0] w_idx_m1;
    logic [AW-1:0] w_addr_full;

    assign w_x_ok    = (x >= c_x_off);
    assign w_dx      = x - c_x_off;
    assign w_s       = w_x_ok ? (w_dx / c_pitch) : 10'd0;
    assign w_xo      = w_dx - (w_s * c_pitch);
    assign w_yo      = y - c_row_y;
    assign w_in_card = w_x_ok && (w_s < c_nslot) && (w_xo < c_card_w) &&
                       (y >= c_row_y) && (w_yo < c_card_h);

    // Slot select by compare so out-of-row slots never index the table.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_s == 10'(i)) begin
                w_idx = r_display[i];
            end
        end
    end

    assign w_idx_ok    = (w_idx != 32'd0) && (w_idx <= c_sprites);
    assign w_draw      = w_in_card && w_idx_ok;
    assign w_idx_m1    = AW'(w_idx) - AW'(1);
    assign w_addr_full = (w_idx_m1 * c_spr_size) + (AW'(w_yo) * c_row_len) + AW'(w_xo);

    logic [ADDR_W-1:0] r_sprite_addr;
    logic [3:0]        r_s1_ctl;           // {draw, active, hSync, vSync}
    logic [3:0]        r_dly [ROM_LAT];    // aligns control with spriteColor
    logic [11:0]       r_color;
    logic              r_hsync;
    logic              r_vsync;
    logic [3:0]        w_tail;

    assign w_tail = r_dly[ROM_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sprite_addr <= '0;
            r_s1_ctl      <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_dly[i] <= '0;
            end
            r_color <= '0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            // Background and bad indices use address 0 so no underflow leaks out.
            r_sprite_addr <= w_draw ? ADDR_W'(w_addr_full) : '0;
            r_s1_ctl      <= {w_draw, active, hSyncIn, vSyncIn};
            r_dly[0]      <= r_s1_ctl;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
            if (!w_tail[2]) begin
                r_color <= 12'h000;
            end else if (w_tail[3]) begin
                r_color <= bus.spriteColor;
            end else begin
                r_color <= 12'hFFF;
            end
            r_hsync <= w_tail[1];
            r_vsync <= w_tail[0];
        end
    end

    assign bus.spriteAddr = r_sprite_addr;
    assign VGA_R = r_color[11:8];
    assign VGA_G = r_color[7:4];
    assign VGA_B = r_color[3:0];
    assign hSync = r_hsync;
    assign vSync = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_vga_card_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_card_renderer
//  Description : Directed self-checking bench for vga_card_renderer with a
//                card-memory responder and a 2-cycle sprite ROM model
//                (colour = addr[11:0] ^ 12'h3C5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_card_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [8:0] y;
    logic       active, hSyncIn, vSyncIn, screenEnd;
    logic       hSync, vSync, fetchErr;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    int errors = 0;
    int checks = 0;

    vga_card_renderer_if #(.ADDR_W(17)) bus ();

    vga_card_renderer dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .active    (active),
        .hSyncIn   (hSyncIn),
        .vSyncIn   (vSyncIn),
        .screenEnd (screenEnd),
        .bus       (bus),
        .hSync     (hSync),
        .vSync     (vSync),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .fetchErr  (fetchErr)
    );

    always #5 clk = ~clk;

    // Sprite ROM model, two-cycle read latency.
    logic [16:0] rom_p1;
    always @(posedge clk) begin
        rom_p1          <= bus.spriteAddr;
        bus.spriteColor <= rom_p1[11:0] ^ 12'h3C5;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Fetch responder controls/results
    logic [31:0] fv [6];
    logic [31:0] seen_addr [6];
    int skip_slot, se_slot, stop_slot, gap;

    task automatic serve_fetch;
        int n;
        screenEnd = 1'b1;
        @(negedge clk);
        screenEnd = 1'b0;
        for (int s = 0; s < 6; s++) begin
            n = 0;
            while (!bus.cardReq && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!bus.cardReq) begin
                checks++; errors++;
                $display("FAIL fetch_req slot %0d: cardReq=0 required 1", s);
                return;
            end
            seen_addr[s] = bus.RAMaddr;
            if (s == stop_slot) return;
            if (s == skip_slot) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.cardReq && n < 40);
                gap = n;
            end else begin
                @(negedge clk);
                if (s == se_slot) begin
                    screenEnd = 1'b1;
                    @(negedge clk);
                    screenEnd = 1'b0;
                end
                bus.cardAck   = 1'b1;
                bus.cardIndex = fv[s];
                @(negedge clk);
                bus.cardAck   = 1'b0;
                bus.cardIndex = 32'hDEAD_BEEF;
            end
        end
    endtask

    task automatic set_fetch(input logic [31:0] a0, a1, a2, a3, a4, a5,
                             input int skip, input int se, input int stop);
        fv[0] = a0; fv[1] = a1; fv[2] = a2; fv[3] = a3; fv[4] = a4; fv[5] = a5;
        skip_slot = skip; se_slot = se; stop_slot = stop;
    endtask

    // Drives a pixel at column offset 1 of slot s, returns the registered address.
    task automatic probe_slot(input int s, output logic [16:0] a);
        x = 10'(10 + 95 * s + 1);
        y = 9'd20;
        active = 1'b1;
        @(negedge clk);
        a = bus.spriteAddr;
    endtask

    task automatic test_reset;
        reset = 1'b1; x = 10'd105; y = 9'd20; active = 1'b1;
        hSyncIn = 1'b1; vSyncIn = 1'b1; screenEnd = 1'b0;
        bus.cardAck = 1'b0; bus.cardIndex = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk);
        checks++; if (bus.cardReq !== 1'b0) begin errors++; $display("FAIL rst_cardReq: got %0b required 0", bus.cardReq); end
        checks++; if (bus.RAMaddr !== 32'd16) begin errors++; $display("FAIL rst_RAMaddr: got %0d required 16", bus.RAMaddr); end
        checks++; if (fetchErr !== 1'b0) begin errors++; $display("FAIL rst_fetchErr: got %0b required 0", fetchErr); end
        checks++; if (bus.spriteAddr !== 17'd0) begin errors++; $display("FAIL rst_spriteAddr: got %0d required 0", bus.spriteAddr); end
        checks++; if ({VGA_R, VGA_G, VGA_B, hSync, vSync} !== 14'd0) begin errors++; $display("FAIL rst_video: got %h required 0", {VGA_R, VGA_G, VGA_B, hSync, vSync}); end
        reset = 1'b0; hSyncIn = 1'b0; vSyncIn = 1'b0; x = 10'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fetch_commit;
        logic [16:0] a;
        logic [16:0] exp_a [6] = '{17'd1, 17'd35701, 17'd107101, 17'd0, 17'd8926, 17'd53551};
        set_fetch(1, 5, 13, 0, 2, 7, -1, -1, -1);
        serve_fetch();
        for (int s = 0; s < 6; s++) begin
            checks++;
            if (seen_addr[s] !== 32'(16 + s)) begin errors++; $display("FAIL fetch_addr slot %0d: got %0d required %0d", s, seen_addr[s], 16 + s); end
        end
        checks++; if (fetchErr !== 1'b0) begin errors++; $display("FAIL fetch_noerr: got %0b required 0", fetchErr); end
        for (int s = 0; s < 6; s++) begin
            probe_slot(s, a);
            checks++;
            if (a !== 17'd0) begin errors++; $display("FAIL precommit_display slot %0d: addr %0d required 0", s, a); end
        end
        serve_fetch();
        for (int s = 0; s < 6; s++) begin
            probe_slot(s, a);
            checks++;
            if (a !== exp_a[s]) begin errors++; $display("FAIL commit_display slot %0d: addr %0d required %0d", s, a, exp_a[s]); end
        end
    endtask

    task automatic test_pixel_path;
        x = 10'd0; y = 9'd20; active = 1'b1; hSyncIn = 1'b0; vSyncIn = 1'b0;
        repeat (6) @(negedge clk);
        x = 10'd105; hSyncIn = 1'b1; vSyncIn = 1'b1;
        @(negedge clk);
        x = 10'd0; hSyncIn = 1'b0; vSyncIn = 1'b0;
        checks++; if (bus.spriteAddr !== 17'd35700) begin errors++; $display("FAIL pix_addr: got %0d required 35700", bus.spriteAddr); end
        repeat (2) @(negedge clk);
        checks++; if (hSync !== 1'b0) begin errors++; $display("FAIL pix_early: hSync %0b required 0 at 3 cycles", hSync); end
        @(negedge clk);
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 12'h8B1) begin errors++; $display("FAIL pix_color: got %h required 8b1", {VGA_R, VGA_G, VGA_B}); end
        checks++; if ({hSync, vSync} !== 2'b11) begin errors++; $display("FAIL pix_sync: got %b required 11", {hSync, vSync}); end
        @(negedge clk);
        checks++; if ({VGA_R, VGA_G, VGA_B, hSync} !== 13'h1FFE) begin errors++; $display("FAIL pix_after: got %h required 1ffe", {VGA_R, VGA_G, VGA_B, hSync}); end
    endtask

    task automatic test_stray_ack;
        logic [16:0] a;
        set_fetch(3, 5, 9, 0, 14, 7, -1, -1, -1);
        serve_fetch();
        bus.cardAck = 1'b1; bus.cardIndex = 32'd1;
        repeat (2) @(negedge clk);
        bus.cardAck = 1'b0; bus.cardIndex = 32'hDEAD_BEEF;
        serve_fetch();
        probe_slot(5, a);
        checks++; if (a !== 17'd53551) begin errors++; $display("FAIL stray_ack slot5: addr %0d required 53551", a); end
        probe_slot(0, a);
        checks++; if (a !== 17'd17851) begin errors++; $display("FAIL stray_ack slot0: addr %0d required 17851", a); end
    endtask

    task automatic test_boundaries;
        logic [9:0]  tx [11] = '{10'd94, 10'd95, 10'd50, 10'd50, 10'd94, 10'd201, 10'd391, 10'd296, 10'd580, 10'd5, 10'd579};
        logic [8:0]  ty [11] = '{9'd20, 9'd20, 9'd125, 9'd124, 9'd20, 9'd20, 9'd20, 9'd20, 9'd20, 9'd20, 9'd20};
        logic        ta [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [16:0] ea [11] = '{17'd17934, 17'd0, 17'd0, 17'd26730, 17'd17934, 17'd71401, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0};
        logic [11:0] ec [11] = '{12'h5CB, 12'hFFF, 12'hFFF, 12'hBAF, 12'h000, 12'h52C, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        for (int i = 0; i < 11; i++) begin
            x = tx[i]; y = ty[i]; active = ta[i];
            @(negedge clk);
            checks++;
            if (bus.spriteAddr !== ea[i]) begin errors++; $display("FAIL bound_addr case %0d: got %0d required %0d", i, bus.spriteAddr, ea[i]); end
            repeat (3) @(negedge clk);
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== ec[i]) begin errors++; $display("FAIL bound_color case %0d: got %h required %h", i, {VGA_R, VGA_G, VGA_B}, ec[i]); end
        end
    endtask

    task automatic test_timeout;
        logic [16:0] a;
        set_fetch(2, 2, 2, 2, 2, 2, 2, -1, -1);
        gap = 0;
        serve_fetch();
        checks++; if (gap !== 16) begin errors++; $display("FAIL timeout_gap: got %0d cycles required 16", gap); end
        checks++; if (seen_addr[3] !== 32'd19) begin errors++; $display("FAIL timeout_next: RAMaddr %0d required 19", seen_addr[3]); end
        checks++; if (fetchErr !== 1'b1) begin errors++; $display("FAIL timeout_err: got %0b required 1", fetchErr); end
        set_fetch(2, 2, 2, 2, 2, 2, -1, -1, -1);
        serve_fetch();
        checks++; if (fetchErr !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b required 1", fetchErr); end
        probe_slot(2, a);
        checks++; if (a !== 17'd71401) begin errors++; $display("FAIL timeout_keep slot2: addr %0d required 71401", a); end
        probe_slot(1, a);
        checks++; if (a !== 17'd8926) begin errors++; $display("FAIL timeout_other slot1: addr %0d required 8926", a); end
    endtask

    task automatic test_screenend_in_wait;
        logic [16:0] a;
        set_fetch(4, 4, 4, 4, 4, 4, -1, 1, -1);
        serve_fetch();
        for (int s = 0; s < 6; s++) begin
            checks++;
            if (seen_addr[s] !== 32'(16 + s)) begin errors++; $display("FAIL se_wait_addr slot %0d: got %0d required %0d", s, seen_addr[s], 16 + s); end
        end
        probe_slot(0, a);
        checks++; if (a !== 17'd8926) begin errors++; $display("FAIL se_wait_nocommit: addr %0d required 8926", a); end
    endtask

    task automatic test_reset_midfetch;
        logic [16:0] a;
        set_fetch(4, 4, 4, 4, 4, 4, -1, -1, 3);
        x = 10'd105; y = 9'd20; active = 1'b1; hSyncIn = 1'b1; vSyncIn = 1'b1;
        serve_fetch();
        checks++; if (seen_addr[3] !== 32'd19) begin errors++; $display("FAIL rstmid_slot3: RAMaddr %0d required 19", seen_addr[3]); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({bus.cardReq, fetchErr, hSync, vSync} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b required 0000", {bus.cardReq, fetchErr, hSync, vSync}); end
        checks++; if (bus.RAMaddr !== 32'd16) begin errors++; $display("FAIL rstmid_RAMaddr: got %0d required 16", bus.RAMaddr); end
        checks++; if (bus.spriteAddr !== 17'd0) begin errors++; $display("FAIL rstmid_spriteAddr: got %0d required 0", bus.spriteAddr); end
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin errors++; $display("FAIL rstmid_color: got %h required 000", {VGA_R, VGA_G, VGA_B}); end
        reset = 1'b0; hSyncIn = 1'b0; vSyncIn = 1'b0;
        probe_slot(1, a);
        checks++; if (a !== 17'd0) begin errors++; $display("FAIL rstmid_cleared: addr %0d required 0", a); end
        repeat (4) @(negedge clk);
        checks++; if (bus.cardReq !== 1'b0) begin errors++; $display("FAIL rstmid_idle: cardReq %0b required 0", bus.cardReq); end
        screenEnd = 1'b1;
        @(negedge clk);
        screenEnd = 1'b0;
        checks++; if ({bus.cardReq, bus.RAMaddr} !== {1'b1, 32'd16}) begin errors++; $display("FAIL rstmid_restart: req %0b addr %0d required 1 / 16", bus.cardReq, bus.RAMaddr); end
    endtask

    initial begin
        test_reset();
        test_fetch_commit();
        test_pixel_path();
        test_stray_ack();
        test_boundaries();
        test_timeout();
        test_screenend_in_wait();
        test_reset_midfetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
